alu_pe_scheduler: RTL
=====================

# alu_pe_scheduler

Per-block scheduler in front of the ALU processing elements: integer, mul/div and dot8. It issues each decoded ALU request to the PE selected by `in_pe_sel` and throttles issue with a per-PE credit counter. It also arbitrates the PEs' variable-latency completions round-robin onto a single registered commit stream. One instance sits in each ALU block, between the dispatch side and the per-PE execute/commit interfaces.

## Interface
- `PE_COUNT`, 3: number of PEs; indices 0=int, 1=muldiv, 2=dot8.
- `MAX_OUT`, 4: maximum outstanding requests per PE (1..15).
- `REQ_W`, 64: request payload width.
- `RSP_W`, 64: response payload width.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `in_valid` in 1: request valid.
- `in_pe_sel` in `PE_SEL_W`: target PE index.
- `in_data` in `REQ_W`: request payload.
- `in_ready` out 1: request accepted this cycle.
- `pe_valid` out `PE_COUNT`: one-hot issue valid.
- `pe_data` out `REQ_W`: request payload, broadcast to all PEs.
- `pe_ready` in `PE_COUNT`: PE can accept.
- `rsp_in_valid` in `PE_COUNT`: PE completion valid.
- `rsp_in_data` in `PE_COUNT*RSP_W`: packed completions; PE i occupies bits [i*RSP_W +: RSP_W].
- `rsp_in_ready` out `PE_COUNT`: completion granted.
- `rsp_out_valid` out 1: commit valid.
- `rsp_out_data` out `RSP_W`: commit payload.
- `rsp_out_pe` out `PE_SEL_W`: source PE of the commit.
- `rsp_out_ready` in 1: commit consumer ready.
- `busy` out 1: any credit below `MAX_OUT` or `rsp_out_valid` high.
- `sel_err` out 1: sticky flag, set by an out-of-range select.

## Operation
- Issue path (combinational):
  - `pe_valid[s] = in_valid && credit[s] != 0` when `s = in_pe_sel` and `s < PE_COUNT`.
  - `in_ready = pe_ready[s] && credit[s] != 0`.
  - `pe_data = in_data`.
- Out-of-range select (`in_pe_sel >= PE_COUNT`): `in_ready=0`, no `pe_valid`, and `sel_err` is set on the next edge until reset. The request stalls forever; it is a design error.
- Credits, one per PE, width `CLOG2(MAX_OUT+1)`:
  - decrement on issue fire to that PE;
  - increment on `rsp_in` grant fire from that PE;
  - issue and grant for the same PE in the same cycle leave the credit unchanged.
  - The credit never exceeds `MAX_OUT`. A completion arriving at full credit is a PE protocol error; the counter saturates.
- Response arbiter, round-robin over `rsp_in_valid`:
  - priority starts at `rr_ptr` and wraps modulo `PE_COUNT`;
  - on a grant, `rr_ptr` moves to winner+1 (wrapping `PE_COUNT-1` to 0);
  - `rr_ptr` holds when there is no grant.
- Output register, one entry:
  - it loads when `!rsp_out_valid || rsp_out_ready`;
  - a grant (`rsp_in_ready[w]=1`) is issued only when the register loads;
  - `rsp_out_data`/`rsp_out_pe` hold stable while `rsp_out_valid && !rsp_out_ready`;
  - `rsp_out_valid` drops on the edge after a fire when no new winner exists.
- No ordering is imposed between PEs; ordering within a PE is preserved.

## Timing
- Reset values:
  - `rsp_out_valid=0`, `rsp_out_data=0`, `rsp_out_pe=0`;
  - all credits `MAX_OUT`, `rr_ptr=0`, `sel_err=0`;
  - `busy=0`, perf counters 0.
- Reset asserted mid-operation: state clears immediately. Outstanding PE work is abandoned; the PEs are reset on the same net.
- Issue latency is 0 cycles (pass-through). Response latency is 1 cycle, from `rsp_in` grant to `rsp_out_valid`.
- Sustained throughput is one issue plus one commit per cycle.
- With all PEs valid continuously and `rsp_out_ready=1`, grants rotate 0,1,2,0,…
- A credit returned in cycle N permits issue in cycle N+1, not N.

## Configuration
`ALU_SCHED_PERF_EN` adds these outputs:
- `perf_credit_stall` (32-bit): increments each cycle where `in_valid`, the select is valid and `credit[s]==0`.
- `perf_rsp_stall` (32-bit): increments each cycle where `rsp_out_valid && !rsp_out_ready`.

Both counters wrap at 2^32. Without the macro these ports and their logic are absent.

## Structure
- Shared package `alu_sched_pkg`:
  - `PE_IDX_INT=0`, `PE_IDX_MDV=1`, `PE_IDX_DOT8=2`;
  - `PE_SEL_W = CLOG2(PE_COUNT)`, minimum 1;
  - the credit counter type.
- Sub-module `alu_pe_rr_arbiter`, parameterized by N. Inputs: request vector, grant-enable. Outputs: one-hot grant and index. It owns `rr_ptr`.

## Test plan
- Reset, then one int request with `in_data=0x11` and PE0 ready: `pe_valid=3'b001` in the same cycle. PE0 returns `0x22`; `rsp_out_valid=1`, `rsp_out_data=0x22`, `rsp_out_pe=0` one cycle later.
- `MAX_OUT=4`, 5 back-to-back requests to muldiv with no responses: 4 accepted, 5th `in_ready=0` and `perf_credit_stall` increments. One muldiv response fires; the 5th is accepted the following cycle.
- All three PEs hold `rsp_in_valid` for 6 cycles with `rsp_out_ready=1`: `rsp_out_pe` sequence is 0,1,2,0,1,2.
- `rsp_out_ready=0` for 3 cycles with PE2 valid: the output holds data and PE stable, and `rsp_in_ready` stays 0. On release, back-to-back commits follow with no bubble.
- Same-cycle issue to PE1 and grant of PE1 at credit 2: credit stays 2.
- `in_pe_sel=3`: `in_ready=0`, `sel_err=1` next cycle and stays set. Asserting `reset` low mid-burst clears all outputs immediately.

Source files
------------

// File: rtl/alu_sched_pkg.sv
// rtl/alu_sched_pkg.sv - shared PE indices, width helpers and credit type for the ALU PE scheduler
package alu_sched_pkg;

   localparam int PE_IDX_INT  = 0;
   localparam int PE_IDX_MDV  = 1;
   localparam int PE_IDX_DOT8 = 2;

   localparam int PE_COUNT_DEF = 3;
   localparam int MAX_OUT_DEF  = 4;

   // Select width never collapses to zero, even for a single PE.
   function automatic int sel_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int credit_w(input int max_out);
      return $clog2(max_out + 1);
   endfunction

   localparam int PE_SEL_W = sel_w(PE_COUNT_DEF);

   typedef logic [credit_w(MAX_OUT_DEF)-1:0] credit_t;

endpackage

// File: rtl/alu_pe_scheduler_if.sv
// rtl/alu_pe_scheduler_if.sv - dispatch, PE issue/completion and commit signals of the ALU PE scheduler
interface alu_pe_scheduler_if
   import alu_sched_pkg::*;
#(
   parameter int PE_COUNT = 3,
   parameter int REQ_W    = 64,
   parameter int RSP_W    = 64
) ();

   localparam int SW = sel_w(PE_COUNT);

   logic                      in_valid;
   logic [SW-1:0]             in_pe_sel;
   logic [REQ_W-1:0]          in_data;
   logic                      in_ready;
   logic [PE_COUNT-1:0]       pe_valid;
   logic [REQ_W-1:0]          pe_data;
   logic [PE_COUNT-1:0]       pe_ready;
   logic [PE_COUNT-1:0]       rsp_in_valid;
   logic [PE_COUNT*RSP_W-1:0] rsp_in_data;
   logic [PE_COUNT-1:0]       rsp_in_ready;
   logic                      rsp_out_valid;
   logic [RSP_W-1:0]          rsp_out_data;
   logic [SW-1:0]             rsp_out_pe;
   logic                      rsp_out_ready;
   logic                      busy;
   logic                      sel_err;

   modport master (
      output in_valid, in_pe_sel, in_data, pe_ready, rsp_in_valid, rsp_in_data, rsp_out_ready,
      input  in_ready, pe_valid, pe_data, rsp_in_ready, rsp_out_valid, rsp_out_data, rsp_out_pe,
             busy, sel_err
   );

   modport slave (
      input  in_valid, in_pe_sel, in_data, pe_ready, rsp_in_valid, rsp_in_data, rsp_out_ready,
      output in_ready, pe_valid, pe_data, rsp_in_ready, rsp_out_valid, rsp_out_data, rsp_out_pe,
             busy, sel_err
   );

endinterface

// File: rtl/alu_pe_rr_arbiter.sv
// rtl/alu_pe_rr_arbiter.sv - round-robin arbiter over N requesters; owns the rotating priority pointer
module alu_pe_rr_arbiter
   import alu_sched_pkg::*;
#(
   parameter int N  = 3,
   parameter int IW = sel_w(N)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [N-1:0]  req,
   input  logic          en,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] gnt_idx
);

   logic [IW-1:0] ptr_q, ptr_d;
   logic          found;

   // Scan from ptr_q upward, wrapping modulo N; first requester wins.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      for (int i = 0; i < N; i++) begin
         for (int p = 0; p < N; p++) begin
            if (!found && req[p] && (p == ((int'(ptr_q) + i) % N))) begin
               found   = 1'b1;
               gnt_idx = IW'(p);
               gnt[p]  = en;
            end
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (en && found) begin
         ptr_d = (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + IW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/alu_pe_scheduler.sv
// rtl/alu_pe_scheduler.sv - credit-throttled ALU PE issue plus round-robin registered commit stream
// Optional perf counters enabled by ALU_SCHED_PERF_EN.
module alu_pe_scheduler
   import alu_sched_pkg::*;
#(
   parameter int PE_COUNT = 3,
   parameter int MAX_OUT  = 4,
   parameter int REQ_W    = 64,
   parameter int RSP_W    = 64
) (
   input  logic                clk,
   input  logic                reset,
   alu_pe_scheduler_if.slave   bus
`ifdef ALU_SCHED_PERF_EN
   ,
   output logic [31:0]         perf_credit_stall,
   output logic [31:0]         perf_rsp_stall
`endif
);

   localparam int SW = sel_w(PE_COUNT);
   localparam int CW = credit_w(MAX_OUT);

   logic [CW-1:0]       credit_q [PE_COUNT];
   logic [CW-1:0]       credit_d [PE_COUNT];
   logic                sel_ok;
   logic                in_ready;
   logic [PE_COUNT-1:0] pe_valid;
   logic [PE_COUNT-1:0] issue;
   logic                stall_credit;
   logic                load;
   logic [PE_COUNT-1:0] gnt;
   logic [SW-1:0]       gnt_idx;
   logic [RSP_W-1:0]    win_data;
   logic                busy;

   logic                out_valid_q, out_valid_d;
   logic [RSP_W-1:0]    out_data_q, out_data_d;
   logic [SW-1:0]       out_pe_q, out_pe_d;
   logic                sel_err_q, sel_err_d;

   assign sel_ok = ({{(32-SW){1'b0}}, bus.in_pe_sel} < 32'(PE_COUNT));

   // Issue is pure pass-through; out-of-range selects leave everything deasserted.
   always_comb begin
      in_ready     = 1'b0;
      pe_valid     = '0;
      issue        = '0;
      stall_credit = 1'b0;
      for (int s = 0; s < PE_COUNT; s++) begin
         if (sel_ok && (bus.in_pe_sel == SW'(s))) begin
            in_ready     = bus.pe_ready[s] && (credit_q[s] != '0);
            pe_valid[s]  = bus.in_valid && (credit_q[s] != '0);
            issue[s]     = bus.in_valid && bus.pe_ready[s] && (credit_q[s] != '0);
            stall_credit = bus.in_valid && (credit_q[s] == '0);
         end
      end
   end

   assign load = !out_valid_q || bus.rsp_out_ready;

   alu_pe_rr_arbiter #(
      .N  (PE_COUNT),
      .IW (SW)
   ) u_rr_arb (
      .clk     (clk),
      .rst_n   (reset),
      .req     (bus.rsp_in_valid),
      .en      (load),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   always_comb begin
      win_data = '0;
      for (int i = 0; i < PE_COUNT; i++) begin
         if (gnt[i]) begin
            win_data = bus.rsp_in_data[i*RSP_W +: RSP_W];
         end
      end
   end

   // A return in the same cycle as an issue cancels out; a stray return at full credit saturates.
   always_comb begin
      for (int s = 0; s < PE_COUNT; s++) begin
         credit_d[s] = credit_q[s];
         if (issue[s] && !gnt[s]) begin
            credit_d[s] = credit_q[s] - CW'(1);
         end else if (gnt[s] && !issue[s] && (credit_q[s] != CW'(MAX_OUT))) begin
            credit_d[s] = credit_q[s] + CW'(1);
         end
      end
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_pe_d    = out_pe_q;
      if (load) begin
         out_valid_d = |gnt;
         if (|gnt) begin
            out_data_d = win_data;
            out_pe_d   = gnt_idx;
         end
      end
      sel_err_d = sel_err_q || (bus.in_valid && !sel_ok);
   end

   always_comb begin
      busy = out_valid_q;
      for (int s = 0; s < PE_COUNT; s++) begin
         if (credit_q[s] != CW'(MAX_OUT)) begin
            busy = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int s = 0; s < PE_COUNT; s++) begin
            credit_q[s] <= CW'(MAX_OUT);
         end
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_pe_q    <= '0;
         sel_err_q   <= 1'b0;
      end else begin
         for (int s = 0; s < PE_COUNT; s++) begin
            credit_q[s] <= credit_d[s];
         end
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_pe_q    <= out_pe_d;
         sel_err_q   <= sel_err_d;
      end
   end

`ifdef ALU_SCHED_PERF_EN
   logic [31:0] perf_credit_q, perf_rsp_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         perf_credit_q <= '0;
         perf_rsp_q    <= '0;
      end else begin
         if (stall_credit) begin
            perf_credit_q <= perf_credit_q + 32'd1;
         end
         if (out_valid_q && !bus.rsp_out_ready) begin
            perf_rsp_q <= perf_rsp_q + 32'd1;
         end
      end
   end

   assign perf_credit_stall = perf_credit_q;
   assign perf_rsp_stall    = perf_rsp_q;
`else
   logic unused_stall;
   assign unused_stall = stall_credit;
`endif

   assign bus.in_ready      = in_ready;
   assign bus.pe_valid      = pe_valid;
   assign bus.pe_data       = bus.in_data;
   assign bus.rsp_in_ready  = gnt;
   assign bus.rsp_out_valid = out_valid_q;
   assign bus.rsp_out_data  = out_data_q;
   assign bus.rsp_out_pe    = out_pe_q;
   assign bus.busy          = busy;
   assign bus.sel_err       = sel_err_q;

endmodule
